// File: rtl/bsg_mux_segmented_buffered.sv
// Per-segment 2:1 merge of data0_i/data1_i into an els_p-deep valid/yumi buffer; one cycle min latency, no bypass.
// ready_o depends only on occupancy, so a full buffer refuses input even when yumi_i is high in the same cycle.
module bsg_mux_segmented_buffered #(
   parameter int width_p    = 16,
   parameter int segments_p = 16,
   parameter int els_p      = 2
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic                         v_i,
   output logic                         ready_o,
   input  logic [width_p-1:0]           data0_i,
   input  logic [width_p-1:0]           data1_i,
   input  logic [segments_p-1:0]        sel_i,
   output logic                         v_o,
   output logic [width_p-1:0]           data_o,
   input  logic                         yumi_i,
   output logic [$clog2(els_p+1)-1:0]   count_o
);

   localparam int sw_lp    = width_p / segments_p;
   localparam int cnt_w_lp = $clog2(els_p + 1);
   localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int depth_lp = (els_p > 1) ? els_p : 2;
   localparam logic [cnt_w_lp-1:0] els_cnt_lp  = cnt_w_lp'(els_p);
   localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);

   generate
      if ((width_p % segments_p) != 0 || els_p < 1) begin : g_bad_params
         $error("bsg_mux_segmented_buffered: width_p must divide by segments_p and els_p must be >= 1");
      end
   endgenerate

   logic [width_p-1:0]  merged;
   logic [width_p-1:0]  mem_q [depth_lp];
   logic [width_p-1:0]  mem_d [depth_lp];
   logic [ptr_w_lp-1:0] wptr_q, wptr_d;
   logic [ptr_w_lp-1:0] rptr_q, rptr_d;
   logic [cnt_w_lp-1:0] count_q, count_d;
   logic                enq, deq;

   always_comb begin
      merged = '0;
      for (int k = 0; k < segments_p; k++) begin
         merged[k*sw_lp +: sw_lp] = sel_i[k] ? data1_i[k*sw_lp +: sw_lp]
                                             : data0_i[k*sw_lp +: sw_lp];
      end
   end

   assign ready_o = (count_q < els_cnt_lp);
   assign v_o     = (count_q != '0);
   assign data_o  = mem_q[rptr_q];
   assign count_o = count_q;

   // A yumi against an empty buffer is ignored rather than corrupting the pointers.
   assign enq = v_i & ready_o;
   assign deq = yumi_i & v_o;

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (enq) begin
         mem_d[wptr_q] = merged;
         wptr_d = (wptr_q == last_ptr_lp) ? '0 : wptr_q + ptr_w_lp'(1);
      end
      if (deq) begin
         rptr_d = (rptr_q == last_ptr_lp) ? '0 : rptr_q + ptr_w_lp'(1);
      end
      case ({enq, deq})
         2'b10:   count_d = count_q + cnt_w_lp'(1);
         2'b01:   count_d = count_q - cnt_w_lp'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         mem_q   <= '{default: '0};
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   a_no_yumi_when_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(yumi_i && !v_o));

endmodule

// File: tb/tb_bsg_mux_segmented_buffered.sv
// Scoreboarded bench for bsg_mux_segmented_buffered across four parameter sets.
module tb_bsg_mux_segmented_buffered;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        v_i  [4];
   logic        yumi [4];
   logic        rdy  [4];
   logic        v_o  [4];
   logic [15:0] d0   [4];
   logic [15:0] d1   [4];
   logic [15:0] dout [4];
   logic [15:0] exp_w[4];
   logic [3:0]  sel0, sel2;
   logic [15:0] sel1;
   logic [1:0]  sel3;
   logic [1:0]  cnt  [3];
   logic        cnt3;

   int tests = 0;
   int fails = 0;
   logic [17:0] sb[$];

   always #5 clk = ~clk;

   // 0: merge/reset, 1: bitwise, 2: els_p=3 full/wrap, 3: els_p=1 streaming
   bsg_mux_segmented_buffered #(.width_p(16), .segments_p(4), .els_p(2)) u0 (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i[0]), .ready_o(rdy[0]),
      .data0_i(d0[0]), .data1_i(d1[0]), .sel_i(sel0), .v_o(v_o[0]),
      .data_o(dout[0]), .yumi_i(yumi[0]), .count_o(cnt[0]));
   bsg_mux_segmented_buffered #(.width_p(16), .segments_p(16), .els_p(2)) u1 (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i[1]), .ready_o(rdy[1]),
      .data0_i(d0[1]), .data1_i(d1[1]), .sel_i(sel1), .v_o(v_o[1]),
      .data_o(dout[1]), .yumi_i(yumi[1]), .count_o(cnt[1]));
   bsg_mux_segmented_buffered #(.width_p(16), .segments_p(4), .els_p(3)) u2 (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i[2]), .ready_o(rdy[2]),
      .data0_i(d0[2]), .data1_i(d1[2]), .sel_i(sel2), .v_o(v_o[2]),
      .data_o(dout[2]), .yumi_i(yumi[2]), .count_o(cnt[2]));
   bsg_mux_segmented_buffered #(.width_p(16), .segments_p(2), .els_p(1)) u3 (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i[3]), .ready_o(rdy[3]),
      .data0_i(d0[3]), .data1_i(d1[3]), .sel_i(sel3), .v_o(v_o[3]),
      .data_o(dout[3]), .yumi_i(yumi[3]), .count_o(cnt3));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic new_word1();
      d0[1]    = 16'($urandom);
      d1[1]    = 16'($urandom);
      sel1     = 16'($urandom);
      exp_w[1] = (d1[1] & sel1) | (d0[1] & ~sel1);
   endtask

   // Monitor: compares every consumed head word against the oldest expected entry of that instance.
   always @(negedge clk) begin
      bit found;
      if (!reset_n) begin
         sb.delete();
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (yumi[i] && v_o[i]) begin
               found = 1'b0;
               for (int k = 0; k < sb.size(); k++) begin
                  if (sb[k][17:16] == 2'(i)) begin
                     chk($sformatf("out%0d", i), 32'(dout[i]), 32'(sb[k][15:0]));
                     sb.delete(k);
                     found = 1'b1;
                     break;
                  end
               end
               if (!found) begin
                  tests++;
                  fails++;
                  $display("FAIL out%0d: unexpected word %h, none expected", i, dout[i]);
               end
            end
            if (v_i[i] && rdy[i]) sb.push_back({2'(i), exp_w[i]});
         end
      end
   end

   initial begin
      int sent, guard, acc;
      logic ok;
      logic [7:0] w;
      for (int i = 0; i < 4; i++) begin
         v_i[i] = 1'b0; yumi[i] = 1'b0; d0[i] = '0; d1[i] = '0; exp_w[i] = '0;
      end
      sel0 = '0; sel1 = '0; sel2 = '0; sel3 = '0;

      // Reset values, during and after reset
      repeat (2) step();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rst_v%0d", i), 32'(v_o[i]), 32'(0));
         chk($sformatf("rst_rdy%0d", i), 32'(rdy[i]), 32'(1));
      end
      chk("rst_cnt0", 32'(cnt[0]), 32'(0));
      chk("rst_cnt3", 32'(cnt3), 32'(0));
      reset_n = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("post_rst_dout%0d", i), 32'(dout[i]), 32'(0));
         chk($sformatf("post_rst_rdy%0d", i), 32'(rdy[i]), 32'(1));
      end

      // Segment merge: 1234 / ABCD / 0101 -> 1B3D
      d0[0] = 16'h1234; d1[0] = 16'hABCD; sel0 = 4'b0101; exp_w[0] = 16'h1B3D; v_i[0] = 1'b1;
      step();
      v_i[0] = 1'b0;
      chk("merge_v", 32'(v_o[0]), 32'(1));
      chk("merge_dat", 32'(dout[0]), 32'h1B3D);
      chk("merge_cnt", 32'(cnt[0]), 32'(1));
      d0[0] = 16'hFFFF; d1[0] = 16'h0000; sel0 = 4'b1010; exp_w[0] = 16'h0F0F; v_i[0] = 1'b1;
      step();
      v_i[0] = 1'b0;
      chk("merge2_cnt", 32'(cnt[0]), 32'(2));
      chk("merge2_rdy", 32'(rdy[0]), 32'(0));
      chk("merge2_head", 32'(dout[0]), 32'h1B3D);

      // Mid-traffic reset discards both entries
      reset_n = 1'b0;
      #1;
      chk("midrst_v", 32'(v_o[0]), 32'(0));
      chk("midrst_cnt", 32'(cnt[0]), 32'(0));
      chk("midrst_dout", 32'(dout[0]), 32'(0));
      chk("midrst_rdy", 32'(rdy[0]), 32'(1));
      step();
      reset_n = 1'b1;
      step();
      chk("midrst_rel_v", 32'(v_o[0]), 32'(0));
      chk("midrst_rel_rdy", 32'(rdy[0]), 32'(1));

      // Bitwise merge stream with random consumer stalls
      sent = 0; guard = 0;
      new_word1();
      v_i[1] = 1'b1;
      while (sent < 1000 && guard < 20000) begin
         yumi[1] = v_o[1] & ($urandom_range(0, 1) == 1);
         ok = rdy[1];
         step();
         guard++;
         if (ok) begin
            sent++;
            if (sent < 1000) new_word1();
            else v_i[1] = 1'b0;
         end
      end
      v_i[1] = 1'b0;
      while (v_o[1] && guard < 20000) begin
         yumi[1] = 1'b1;
         step();
         guard++;
      end
      yumi[1] = 1'b0;
      chk("bitwise_sent", 32'(sent), 32'(1000));
      chk("bitwise_drained", 32'(v_o[1]), 32'(0));

      // Full / backpressure on els_p=3
      acc = 0; sel2 = 4'h0; d1[2] = 16'hFFFF; v_i[2] = 1'b1;
      for (int n = 0; n < 5; n++) begin
         d0[2] = 16'h1000 + 16'(acc);
         exp_w[2] = d0[2];
         chk($sformatf("full_rdy_c%0d", n), 32'(rdy[2]), 32'(n < 3));
         ok = rdy[2];
         step();
         if (ok) acc++;
      end
      v_i[2] = 1'b0;
      chk("full_acc", 32'(acc), 32'(3));
      chk("full_cnt", 32'(cnt[2]), 32'(3));
      yumi[2] = 1'b1;
      chk("full_rdy_yumi", 32'(rdy[2]), 32'(0));
      step();
      yumi[2] = 1'b0;
      chk("full_rdy_after", 32'(rdy[2]), 32'(1));
      chk("full_cnt_after", 32'(cnt[2]), 32'(2));

      // Simultaneous enqueue/dequeue at count=1, pointers wrap
      yumi[2] = 1'b1;
      step();
      chk("wrap_start_cnt", 32'(cnt[2]), 32'(1));
      sel2 = 4'hF;
      for (int n = 0; n < 10; n++) begin
         d1[2] = 16'h2000 + 16'(n);
         d0[2] = ~d1[2];
         exp_w[2] = 16'h2000 + 16'(n);
         v_i[2] = 1'b1;
         yumi[2] = 1'b1;
         step();
         chk($sformatf("wrap_cnt%0d", n), 32'(cnt[2]), 32'(1));
      end
      v_i[2] = 1'b0;
      guard = 0;
      while (v_o[2] && guard < 20) begin
         yumi[2] = 1'b1;
         step();
         guard++;
      end
      yumi[2] = 1'b0;
      chk("wrap_drained", 32'(v_o[2]), 32'(0));

      // els_p=1 streaming: one word every two cycles
      acc = 0; sel3 = 2'b10;
      for (int n = 0; n < 12; n++) begin
         w = 8'h30 + 8'(acc);
         d0[3] = {8'h5A, w};
         d1[3] = {w, 8'hA5};
         exp_w[3] = {w, w};
         v_i[3] = 1'b1;
         yumi[3] = v_o[3];
         chk($sformatf("els1_rdy%0d", n), 32'(rdy[3]), 32'((n % 2) == 0));
         ok = rdy[3];
         step();
         if (ok) acc++;
      end
      v_i[3] = 1'b0;
      yumi[3] = v_o[3];
      step();
      yumi[3] = 1'b0;
      chk("els1_acc", 32'(acc), 32'(6));
      chk("els1_cnt_end", 32'(cnt3), 32'(0));

      step();
      chk("sb_empty", 32'(sb.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
